// File: rtl/squash_pkg.sv
// Shared types and constants for the solo_squash input front end.
package squash_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_PAUSE = 0;
  localparam int BTN_NEW   = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_START   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_PAUSED  = 2'd3
  } state_t;

endpackage

// File: rtl/squash_debounce.sv
// Two-flop synchroniser plus counter debounce for one active-low button.
// fall pulses for one cycle after the debounced level goes 1->0.
module squash_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_n,
  output logic deb_n,
  output logic fall
);

  localparam logic [DB_BITS-1:0] DB_MAX = '1;

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               deb_q, deb_d;
  logic               fall_q, fall_d;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DB_MAX) begin
        deb_d  = sync2_q;
        fall_d = deb_q;
      end else begin
        cnt_d = cnt_q + DB_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_n = deb_q;
  assign fall  = fall_q;

endmodule

// File: rtl/squash_input_ctrl.sv
// Button front end for solo_squash: debounce, game-session FSM, idle timeout.
//   state      | meaning
//   ST_ATTRACT | demo/attract, core paused, waits for new_game press
//   ST_START   | new_game held to core for at least one full frame
//   ST_PLAY    | game running, paddle keys passed through
//   ST_PAUSED  | game frozen, paddle keys forced released
module squash_input_ctrl
  import squash_pkg::*;
#(
  parameter int DB_BITS     = 16,
  parameter int IDLE_FRAMES = 1800
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               frame_tick,
  output logic               game_pause_n,
  output logic               game_new_game_n,
  output logic               game_down_n,
  output logic               game_up_n,
  output logic [1:0]         state
);

  localparam bit IDLE_EN = (IDLE_FRAMES > 0);
  localparam int IW      = IDLE_EN ? $clog2(IDLE_FRAMES + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_EN ? IDLE_FRAMES - 1 : 0);
  localparam logic [IW-1:0] IDLE_SAT  = IW'(IDLE_EN ? IDLE_FRAMES : 0);

  logic [NUM_BTN-1:0] deb_n;
  logic [NUM_BTN-1:0] fall;

  for (genvar i = 0; i < NUM_BTN; i++) begin : gen_db
    squash_debounce #(.DB_BITS(DB_BITS)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_n   (btn_n[i]),
      .deb_n   (deb_n[i]),
      .fall    (fall[i])
    );
  end

  state_t        state_q, state_d;
  logic          tick_seen_q, tick_seen_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          pause_n_q, pause_n_d;
  logic          new_n_q, new_n_d;
  logic          down_n_q, down_n_d;
  logic          up_n_q, up_n_d;
  logic          new_press, pause_press, idle_expire;

  assign new_press   = fall[BTN_NEW];
  assign pause_press = fall[BTN_PAUSE];
  assign idle_expire = IDLE_EN && frame_tick && (idle_q == IDLE_LAST) &&
                       ((state_q == ST_PLAY) || (state_q == ST_PAUSED));

  always_comb begin
    state_d     = state_q;
    tick_seen_d = 1'b0;
    idle_d      = idle_q;

    case (state_q)
      ST_ATTRACT: if (new_press) state_d = ST_START;
      ST_START: begin
        if (new_press)                     state_d = ST_START;
        else if (frame_tick && tick_seen_q) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (new_press)        state_d = ST_START;
        else if (pause_press) state_d = ST_PAUSED;
        else if (idle_expire) state_d = ST_ATTRACT;
      end
      ST_PAUSED: begin
        if (new_press)        state_d = ST_START;
        else if (pause_press) state_d = ST_PLAY;
        else if (idle_expire) state_d = ST_ATTRACT;
      end
      default: state_d = ST_ATTRACT;
    endcase

    // A re-press in START counts as a fresh entry, so the frame count restarts.
    if ((state_q == ST_START) && (state_d == ST_START) && !new_press)
      tick_seen_d = tick_seen_q | frame_tick;

    if ((|fall) || !(&deb_n) || (state_d != state_q))
      idle_d = '0;
    else if (frame_tick && (idle_q != IDLE_SAT))
      idle_d = idle_q + IW'(1);

    pause_n_d = (state_d == ST_START) || (state_d == ST_PLAY);
    new_n_d   = (state_d != ST_START);
    down_n_d  = (state_d == ST_PLAY) ? deb_n[BTN_DOWN] : 1'b1;
    up_n_d    = (state_d == ST_PLAY) ? deb_n[BTN_UP]   : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ATTRACT;
      tick_seen_q <= 1'b0;
      idle_q      <= '0;
      pause_n_q   <= 1'b0;
      new_n_q     <= 1'b1;
      down_n_q    <= 1'b1;
      up_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_seen_q <= tick_seen_d;
      idle_q      <= idle_d;
      pause_n_q   <= pause_n_d;
      new_n_q     <= new_n_d;
      down_n_q    <= down_n_d;
      up_n_q      <= up_n_d;
    end
  end

  assign state           = state_q;
  assign game_pause_n    = pause_n_q;
  assign game_new_game_n = new_n_q;
  assign game_down_n     = down_n_q;
  assign game_up_n       = up_n_q;

endmodule

// File: tb/tb_squash_input_ctrl.sv
// Bench for squash_input_ctrl: directed table, corner sequences, random vs reference model.
module tb_squash_input_ctrl;

  localparam int DB_BITS = 2;
  localparam int DB_MAX  = 3;
  localparam int IDLE    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_n = 4'hF;
  logic       frame_tick = 1'b0;
  logic       game_pause_n, game_new_game_n, game_down_n, game_up_n;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  squash_input_ctrl #(.DB_BITS(DB_BITS), .IDLE_FRAMES(IDLE)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .btn_n           (btn_n),
    .frame_tick      (frame_tick),
    .game_pause_n    (game_pause_n),
    .game_new_game_n (game_new_game_n),
    .game_down_n     (game_down_n),
    .game_up_n       (game_up_n),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-button history of synchronised samples, session rules
  int         m_state, m_idle, m_cnt[4];
  bit         m_tick_seen;
  bit   [3:0] m_s1, m_s2, m_deb, m_fall;
  bit   [3:0] m_out; // {up_n, down_n, new_n, pause_n}

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0; m_idle = 0; m_tick_seen = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF; m_fall = 4'h0;
      foreach (m_cnt[b]) m_cnt[b] = 0;
      m_out = 4'b1110;
    end else begin
      bit [3:0] pf, pd;
      int ns;
      bit expire;
      pf = m_fall; pd = m_deb;
      expire = frame_tick && (m_idle == IDLE - 1) && (m_state >= 2);
      ns = m_state;
      if (pf[1]) ns = 1;
      else if (m_state == 1 && frame_tick && m_tick_seen) ns = 2;
      else if (m_state >= 2 && pf[0]) ns = (m_state == 2) ? 3 : 2;
      else if (expire) ns = 0;
      m_tick_seen = (m_state == 1 && ns == 1 && !pf[1]) ? (m_tick_seen | frame_tick) : 1'b0;
      if (pf != 0 || pd != 4'hF || ns != m_state) m_idle = 0;
      else if (frame_tick && m_idle < IDLE) m_idle++;
      m_state = ns;
      m_out[0] = (ns == 1 || ns == 2);
      m_out[1] = (ns != 1);
      m_out[2] = (ns == 2) ? pd[2] : 1'b1;
      m_out[3] = (ns == 2) ? pd[3] : 1'b1;
      for (int b = 0; b < 4; b++) begin
        m_fall[b] = 1'b0;
        if (m_s2[b] != m_deb[b]) begin
          if (m_cnt[b] == DB_MAX) begin
            m_fall[b] = m_deb[b];
            m_deb[b]  = m_s2[b];
            m_cnt[b]  = 0;
          end else m_cnt[b]++;
        end else m_cnt[b] = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("model_state",   int'(state),           m_state);
      chk("model_pause_n", int'(game_pause_n),    int'(m_out[0]));
      chk("model_new_n",   int'(game_new_game_n), int'(m_out[1]));
      chk("model_down_n",  int'(game_down_n),     int'(m_out[2]));
      chk("model_up_n",    int'(game_up_n),       int'(m_out[3]));
    end
  end

  typedef struct {
    logic [3:0] btn;
    int         wait_cyc;
    int         ticks;
    int         st;
    logic       pause_n, new_n, down_n, up_n;
  } vec_t;

  vec_t tbl[18];

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1; @(negedge clk);
      frame_tick = 1'b0; cycles(2);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input logic p, input logic nw,
                         input logic dn, input logic up);
    chk({tag, "_state"},   int'(state),           st);
    chk({tag, "_pause_n"}, int'(game_pause_n),    int'(p));
    chk({tag, "_new_n"},   int'(game_new_game_n), int'(nw));
    chk({tag, "_down_n"},  int'(game_down_n),     int'(dn));
    chk({tag, "_up_n"},    int'(game_up_n),       int'(up));
  endtask

  initial begin
    tbl[0]  = '{4'b1101, 10, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{4'b1111, 10, 2, 2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{4'b0111, 10, 0, 2, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{4'b0110, 10, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{4'b0111, 10, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{4'b0110, 10, 0, 2, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{4'b1111, 10, 0, 2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{4'b1111,  2, 3, 2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{4'b1011, 10, 0, 2, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{4'b1111, 10, 3, 2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{4'b1111,  0, 1, 0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{4'b1110, 10, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{4'b1101, 10, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{4'b1111, 10, 2, 2, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{4'b1110, 10, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[15] = '{4'b1111, 10, 0, 3, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[16] = '{4'b1100, 10, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{4'b1111, 10, 2, 2, 1'b1, 1'b1, 1'b1, 1'b1};

    cycles(3);
    chk_all("reset", 0, 1'b0, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b1;
    chk_en  = 1;
    cycles(2);

    for (int i = 0; i < 18; i++) begin
      btn_n = tbl[i].btn;
      cycles(tbl[i].wait_cyc);
      ticks(tbl[i].ticks);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pause_n, tbl[i].new_n,
              tbl[i].down_n, tbl[i].up_n);
    end

    // short glitch on pause must not register
    btn_n = 4'b1110; cycles(3);
    btn_n = 4'b1111; cycles(10);
    chk("glitch_state", int'(state), 2);

    // held pause: debounced level falls on edge DB_MAX+3, state follows one edge later
    btn_n = 4'b1110;
    cycles(DB_MAX + 3);
    chk("latency_before", int'(state), 2);
    cycles(1);
    chk("latency_after", int'(state), 3);
    btn_n = 4'b1111; cycles(10);
    chk("latency_single_press", int'(state), 3);

    // async reset mid-PLAY with up key held
    btn_n = 4'b1110; cycles(10);
    btn_n = 4'b0111; cycles(10);
    chk("pre_reset_state", int'(state), 2);
    chk("pre_reset_up_n", int'(game_up_n), 0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 1'b0, 1'b1, 1'b1, 1'b1);
    btn_n = 4'hF;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)
        btn_n = ~(4'($urandom) & 4'($urandom));
      frame_tick = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    frame_tick = 1'b0;
    btn_n = 4'hF;
    cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
